// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct constants and write-back select types
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2a;
    localparam logic [5:0] F_SLTU = 6'h2b;

    typedef enum logic [1:0] {
        SRC_ALU,
        SRC_DM,
        SRC_PC8,
        SRC_MD
    } src_sel_t;

    typedef enum logic [2:0] {
        LD_W,
        LD_B,
        LD_BU,
        LD_H,
        LD_HU
    } ld_size_t;

    typedef enum logic [1:0] {
        DST_RD,
        DST_RT,
        DST_RA
    } dst_sel_t;

endpackage

// File: rtl/wb_decode.sv
// rtl/wb_decode.sv - instruction to write-back control (write, dest, source, load size)
module wb_decode
    import mips_pkg::*;
#(
    parameter int HAS_MD = 1
) (
    input  logic [31:0] instr,
    output logic        write,
    output dst_sel_t    dst,
    output src_sel_t    src,
    output ld_size_t    ld
);

    localparam bit MD_EN = (HAS_MD != 0);

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_fields;

    assign op            = instr[31:26];
    assign funct         = instr[5:0];
    assign unused_fields = ^instr[25:6];

    always_comb begin
        write = 1'b0;
        dst   = DST_RD;
        src   = SRC_ALU;
        ld    = LD_W;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_SLL, F_SRL, F_SRA, F_ADDU, F_SUBU, F_AND, F_OR,
                    F_XOR, F_NOR, F_SLT, F_SLTU: write = 1'b1;
                    F_JALR: begin
                        write = 1'b1;
                        src   = SRC_PC8;
                    end
                    F_MFHI, F_MFLO: begin
                        write = MD_EN;
                        src   = SRC_MD;
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                write = 1'b1;
                dst   = DST_RT;
            end
            OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
                write = 1'b1;
                dst   = DST_RT;
                src   = SRC_DM;
                case (op)
                    OP_LB:   ld = LD_B;
                    OP_LBU:  ld = LD_BU;
                    OP_LH:   ld = LD_H;
                    OP_LHU:  ld = LD_HU;
                    default: ld = LD_W;
                endcase
            end
            OP_JAL: begin
                write = 1'b1;
                dst   = DST_RA;
                src   = SRC_PC8;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - registered M/W stage with load extension and result select
module wb_stage
    import mips_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int HAS_MD = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_W,
    input  logic             flush_W,
    input  logic [31:0]      instr_M,
    input  logic [WIDTH-1:0] ALUout_M,
    input  logic [WIDTH-1:0] ReadData_M,
    input  logic [WIDTH-1:0] PC8_M,
    input  logic [WIDTH-1:0] MDout_M,
    output logic             RegWrite_W,
    output logic [4:0]       A3_W,
    output logic [WIDTH-1:0] result_W,
    output logic             Tnew_zero_W,
    output logic [31:0]      instr_W
);

    logic [31:0]      instr_q;
    logic [WIDTH-1:0] alu_q;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] pc8_q;
    logic [WIDTH-1:0] md_q;
    logic             valid_q;

    always_ff @(posedge clk) begin
        if (reset || flush_W) begin
            instr_q <= '0;
            alu_q   <= '0;
            rdata_q <= '0;
            pc8_q   <= '0;
            md_q    <= '0;
            valid_q <= 1'b0;
        end else if (en_W) begin
            instr_q <= instr_M;
            alu_q   <= ALUout_M;
            rdata_q <= ReadData_M;
            pc8_q   <= PC8_M;
            md_q    <= MDout_M;
            valid_q <= 1'b1;
        end
    end

    logic     dec_write;
    dst_sel_t dec_dst;
    src_sel_t dec_src;
    ld_size_t dec_ld;

    wb_decode #(.HAS_MD(HAS_MD)) u_decode (
        .instr (instr_q),
        .write (dec_write),
        .dst   (dec_dst),
        .src   (dec_src),
        .ld    (dec_ld)
    );

    logic [4:0] dest;

    always_comb begin
        dest = instr_q[15:11];
        case (dec_dst)
            DST_RT:  dest = instr_q[20:16];
            DST_RA:  dest = 5'd31;
            default: dest = instr_q[15:11];
        endcase
    end

    assign RegWrite_W  = dec_write & valid_q & (dest != 5'd0);
    assign A3_W        = RegWrite_W ? dest : 5'd0;
    assign Tnew_zero_W = RegWrite_W;
    assign instr_W     = instr_q;

    // Byte lane follows the address low bits; halfword only looks at a[1].
    logic [7:0]       dm_byte;
    logic [15:0]      dm_half;
    logic [WIDTH-1:0] dm_ext;

    assign dm_byte = rdata_q[{alu_q[1:0], 3'b000} +: 8];
    assign dm_half = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        dm_ext = rdata_q;
        case (dec_ld)
            LD_B:    dm_ext = {{(WIDTH-8){dm_byte[7]}}, dm_byte};
            LD_BU:   dm_ext = {{(WIDTH-8){1'b0}}, dm_byte};
            LD_H:    dm_ext = {{(WIDTH-16){dm_half[15]}}, dm_half};
            LD_HU:   dm_ext = {{(WIDTH-16){1'b0}}, dm_half};
            default: dm_ext = rdata_q;
        endcase
    end

    logic [WIDTH-1:0] md_val;
    logic [WIDTH-1:0] result_sel;

    assign md_val = (HAS_MD != 0) ? md_q : '0;

    always_comb begin
        result_sel = alu_q;
        case (dec_src)
            SRC_DM:  result_sel = dm_ext;
            SRC_PC8: result_sel = pc8_q;
            SRC_MD:  result_sel = md_val;
            default: result_sel = alu_q;
        endcase
    end

    assign result_W = RegWrite_W ? result_sel : '0;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage against a behavioural model
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset, en_W, flush_W;
    logic [31:0] instr_M, ALUout_M, ReadData_M, PC8_M, MDout_M;

    logic        rw_a, tn_a, rw_b, tn_b;
    logic [4:0]  a3_a, a3_b;
    logic [31:0] res_a, res_b, iw_a, iw_b;

    always #5 clk = ~clk;

    wb_stage #(.WIDTH(32), .HAS_MD(1)) dut (
        .clk(clk), .reset(reset), .en_W(en_W), .flush_W(flush_W),
        .instr_M(instr_M), .ALUout_M(ALUout_M), .ReadData_M(ReadData_M),
        .PC8_M(PC8_M), .MDout_M(MDout_M),
        .RegWrite_W(rw_a), .A3_W(a3_a), .result_W(res_a),
        .Tnew_zero_W(tn_a), .instr_W(iw_a)
    );

    wb_stage #(.WIDTH(32), .HAS_MD(0)) dut_nomd (
        .clk(clk), .reset(reset), .en_W(en_W), .flush_W(flush_W),
        .instr_M(instr_M), .ALUout_M(ALUout_M), .ReadData_M(ReadData_M),
        .PC8_M(PC8_M), .MDout_M(MDout_M),
        .RegWrite_W(rw_b), .A3_W(a3_b), .result_W(res_b),
        .Tnew_zero_W(tn_b), .instr_W(iw_b)
    );

    typedef struct packed {
        logic        rw;
        logic [4:0]  a3;
        logic [31:0] res;
        logic [31:0] instr;
    } exp_t;

    typedef struct packed {
        exp_t md1;
        exp_t md0;
    } pair_t;

    pair_t sb[$];
    int    errors = 0;
    int    checks = 0;

    // Behavioural model of one latched M/W entry.
    function automatic exp_t ref_wb(input logic [31:0] ins, input logic [31:0] alu,
                                    input logic [31:0] dm, input logic [31:0] pc8,
                                    input logic [31:0] md, input bit valid, input bit has_md);
        exp_t        e;
        bit          wr = 0;
        int          dst = 0;
        logic [31:0] res = 0;
        logic [31:0] sh;
        logic [15:0] hw;
        byte         sbyte;
        shortint     shalf;
        int          op = int'(ins[31:26]);
        int          fn = int'(ins[5:0]);
        int          rt = int'(ins[20:16]);
        int          rd = int'(ins[15:11]);
        sh    = dm >> (8 * int'(alu[1:0]));
        hw    = alu[1] ? dm[31:16] : dm[15:0];
        sbyte = byte'(sh[7:0]);
        shalf = shortint'(hw);
        if (op == 0) begin
            if (fn inside {'h00, 'h02, 'h03, 'h21, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2a, 'h2b}) begin
                wr = 1; dst = rd; res = alu;
            end else if (fn == 'h09) begin
                wr = 1; dst = rd; res = pc8;
            end else if (fn == 'h10 || fn == 'h12) begin
                wr = has_md; dst = rd; res = md;
            end
        end else if (op >= 'h08 && op <= 'h0f) begin
            wr = 1; dst = rt; res = alu;
        end else if (op == 'h23) begin
            wr = 1; dst = rt; res = dm;
        end else if (op == 'h20) begin
            wr = 1; dst = rt; res = 32'(int'(sbyte));
        end else if (op == 'h24) begin
            wr = 1; dst = rt; res = {24'd0, sh[7:0]};
        end else if (op == 'h21) begin
            wr = 1; dst = rt; res = 32'(int'(shalf));
        end else if (op == 'h25) begin
            wr = 1; dst = rt; res = {16'd0, hw};
        end else if (op == 'h03) begin
            wr = 1; dst = 31; res = pc8;
        end
        e.rw    = wr && valid && (dst != 0);
        e.a3    = e.rw ? 5'(dst) : 5'd0;
        e.res   = e.rw ? res : 32'd0;
        e.instr = ins;
        return e;
    endfunction

    // Model register contents after the coming edge.
    logic [31:0] m_ins, m_alu, m_dm, m_pc8, m_md;
    bit          m_valid;
    pair_t       pending;
    bit          pending_ok = 0;

    task automatic step(input bit rst, input bit en, input bit fl, input logic [31:0] ins,
                        input logic [31:0] alu, input logic [31:0] dm,
                        input logic [31:0] pc8, input logic [31:0] md);
        @(posedge clk);
        #1;
        if (pending_ok) sb.push_back(pending);
        reset = rst; en_W = en; flush_W = fl;
        instr_M = ins; ALUout_M = alu; ReadData_M = dm; PC8_M = pc8; MDout_M = md;
        if (rst || fl) begin
            m_ins = 0; m_alu = 0; m_dm = 0; m_pc8 = 0; m_md = 0; m_valid = 0;
        end else if (en) begin
            m_ins = ins; m_alu = alu; m_dm = dm; m_pc8 = pc8; m_md = md; m_valid = 1;
        end
        pending.md1 = ref_wb(m_ins, m_alu, m_dm, m_pc8, m_md, m_valid, 1'b1);
        pending.md0 = ref_wb(m_ins, m_alu, m_dm, m_pc8, m_md, m_valid, 1'b0);
        pending_ok  = (rst || fl || en || pending_ok);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            pair_t p;
            p = sb.pop_front();
            chk("RegWrite_W",       {31'd0, rw_a}, {31'd0, p.md1.rw});
            chk("Tnew_zero_W",      {31'd0, tn_a}, {31'd0, p.md1.rw});
            chk("A3_W",             {27'd0, a3_a}, {27'd0, p.md1.a3});
            chk("result_W",         res_a,         p.md1.res);
            chk("instr_W",          iw_a,          p.md1.instr);
            chk("nomd.RegWrite_W",  {31'd0, rw_b}, {31'd0, p.md0.rw});
            chk("nomd.Tnew_zero_W", {31'd0, tn_b}, {31'd0, p.md0.rw});
            chk("nomd.A3_W",        {27'd0, a3_b}, {27'd0, p.md0.a3});
            chk("nomd.result_W",    res_b,         p.md0.res);
        end
    end

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, 5'd3, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd);
        return {6'h00, 5'd4, 5'd6, rd, 5'd0, fn};
    endfunction

    localparam logic [31:0] BYTES = 32'h80FF7F01;
    localparam logic [31:0] HALFS = 32'h80011234;

    initial begin
        logic [5:0] ops[$]    = '{6'h00, 6'h00, 6'h00, 6'h03, 6'h08, 6'h09, 6'h0a, 6'h0d,
                                  6'h0f, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h2b, 6'h04,
                                  6'h02, 6'h3f};
        logic [5:0] functs[$] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h10, 6'h12, 6'h18,
                                  6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
                                  6'h2b, 6'h11};
        reset = 1; en_W = 0; flush_W = 0;
        instr_M = 0; ALUout_M = 0; ReadData_M = 0; PC8_M = 0; MDout_M = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 32'hFFFF_FFFF, 1, 2, 3, 4);
        step(0, 1, 0, itype(6'h23, 5'd5, 16'h0), 32'h100, 32'hDEADBEEF, 32'h8, 32'h0);
        for (int a = 0; a < 4; a++)
            step(0, 1, 0, itype(6'h20, 5'd7, 16'h0), 32'h200 + 32'(a), BYTES, 0, 0);
        step(0, 1, 0, itype(6'h24, 5'd7, 16'h0), 32'h203, BYTES, 0, 0);
        step(0, 1, 0, itype(6'h21, 5'd2, 16'h0), 32'h302, HALFS, 0, 0);
        step(0, 1, 0, itype(6'h25, 5'd2, 16'h0), 32'h300, HALFS, 0, 0);
        step(0, 1, 0, {6'h03, 26'h0000C00}, 32'h55, 0, 32'h00003008, 0);
        step(0, 1, 0, rtype(6'h21, 5'd0), 32'h1234, 0, 0, 0);
        step(0, 1, 0, rtype(6'h21, 5'd9), 32'hCAFE0001, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, $urandom, $urandom, $urandom, $urandom, $urandom);
        step(0, 1, 1, rtype(6'h21, 5'd10), 32'h77, 0, 0, 0);
        step(0, 1, 0, rtype(6'h10, 5'd8), 0, 0, 0, 32'h12345678);
        step(0, 1, 0, rtype(6'h12, 5'd8), 0, 0, 0, 32'h9ABCDEF0);
        step(1, 1, 0, rtype(6'h21, 5'd11), 32'h99, 0, 0, 0);
        step(1, 1, 1, rtype(6'h21, 5'd11), 32'h99, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            logic [5:0]  op;
            op  = ops[$urandom_range(0, ops.size() - 1)];
            ins = $urandom;
            ins[31:26] = op;
            if (op == 6'h00) ins[5:0] = functs[$urandom_range(0, functs.size() - 1)];
            step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 80,
                 $urandom_range(0, 99) < 8, ins, $urandom, $urandom, $urandom, $urandom);
        end

        step(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised write-back stage for the five-stage pipelined MIPS core. It owns the M/W pipeline register and decodes the latched instruction to pick the register-file destination and result source. It sign- or zero-extends sub-word loads from the lane given by the address low bits, and drives the register-file write port and the W-stage forwarding bus. It replaces the combinational write-back selector with a registered, stall/flush-aware stage that supports byte, halfword and HI/LO results.

## Interface
- `WIDTH`, default 32: datapath width. Must be 32 when `HAS_MD`=1 or sub-word loads are used.
- `HAS_MD`, default 1: 1 enables the HI/LO result source. 0 ties that source to 0 and decodes mfhi/mflo as no-write.
- `clk`, input, 1 bit: single clock; all state updates on the rising edge.
- `reset`, input, 1 bit: synchronous, active-high.
- `en_W`, input, 1 bit: 1 loads the M/W register; 0 holds it (stall).
- `flush_W`, input, 1 bit: 1 loads a bubble (all-zero instruction, valid=0). Takes priority over `en_W`.
- `instr_M`, input, 32 bits: instruction leaving the M stage.
- `ALUout_M`, input, `WIDTH`: ALU result; also the load address.
- `ReadData_M`, input, `WIDTH`: raw aligned data-memory word.
- `PC8_M`, input, `WIDTH`: PC+8 link value.
- `MDout_M`, input, `WIDTH`: HI or LO value, already selected for mfhi/mflo.
- `RegWrite_W`, output, 1 bit: register-file write enable.
- `A3_W`, output, 5 bits: destination register number.
- `result_W`, output, `WIDTH`: write data.
- `Tnew_zero_W`, output, 1 bit: 1 when `RegWrite_W`=1. The result is forwardable this cycle.
- `instr_W`, output, 32 bits: latched instruction, for the hazard unit.

## Operation
**Pipeline register**
- Fields: instr, ALUout, ReadData, PC8, MDout, valid.
- Register update rule:
  - `reset` clears every field to 0.
  - Otherwise `flush_W` clears every field to 0.
  - Otherwise `en_W` loads the M inputs, with valid=1.
  - Otherwise the register holds its value.
- An all-zero instruction is sll $0,$0,0, so a bubble writes nothing.

**Decode** (combinational, from latched instr; opcode=[31:26], funct=[5:0]):
- **R-type (op 0x00):**
  - addu/subu/and/or/slt/sltu/sll/srl/sra/xor/nor: dest rd, source ALU.
  - jalr (funct 0x09): dest rd, source PC8.
  - mfhi (0x10) and mflo (0x12): dest rd, source MD.
  - jr, mult, multu, div, divu, mthi, mtlo: no write.
- **I-type ALU** (addi 0x08, addiu 0x09, slti 0x0a, sltiu 0x0b, andi 0x0c, ori 0x0d, xori 0x0e, lui 0x0f): dest rt, source ALU.
- **Loads:**
  - lw 0x23: dest rt, source DM word.
  - lb 0x20 and lbu 0x24: dest rt, source DM byte.
  - lh 0x21 and lhu 0x25: dest rt, source DM half.
- **jal (0x03):** dest 31, source PC8.
- **All other opcodes** (stores, branches, j, undefined): no write.
- **Write enable:** `RegWrite_W` = decoded write AND valid AND (`A3_W`≠0). `A3_W` is forced to 0 when no write.

**Load extension**, with `a` = ALUout[1:0]:
- Byte: selects ReadData[8a+7:8a].
- Half: selects ReadData[15:0] for a[1]=0, [31:16] for a[1]=1. a[0] is ignored; alignment is the M stage's responsibility.
- lb and lh sign-extend to `WIDTH`; lbu and lhu zero-extend.

**Result mux:** ALU / DM (extended) / PC8 / MD. `result_W`=0 when `RegWrite_W`=0.

## Timing
- Latency: one cycle from M inputs to W outputs. All outputs are combinational from the registered state.
- Reset values: `instr_W`=0, `RegWrite_W`=0, `A3_W`=0, `result_W`=0, `Tnew_zero_W`=0.
- `en_W`=0 holds the outputs; the register file is written again with the same value, which is harmless.
- `flush_W` and `en_W` both high in the same cycle: a bubble is loaded.
- `reset` asserted mid-stream: outputs are 0 on the next edge, regardless of `en_W` and `flush_W`.
- The register file writes on the same edge, write-first. The hazard unit may forward `result_W` in the same cycle.

## Structure
- Package `mips_pkg`:
  - opcode and funct localparams.
  - Source-select enum: `SRC_ALU`, `SRC_DM`, `SRC_PC8`, `SRC_MD`.
  - Load-size enum: `LD_W`, `LD_B`, `LD_BU`, `LD_H`, `LD_HU`.
- Sub-module `wb_decode`: combinational, instr → {write, dest sel, src, load size}. The hazard unit reuses it.
- Load extension and the result mux live inline in `wb_stage`.

## Test plan
- Reset, then lw with ReadData=0xDEADBEEF and rt=5, `en_W`=1: next cycle `RegWrite_W`=1, `A3_W`=5, `result_W`=0xDEADBEEF.
- lb and lbu with ReadData=0x80FF7F01 and a=0..3:
  - lb results: 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
  - lbu for a=3: 0x00000080.
- lh with a=2 and ReadData=0x8001_1234: 0xFFFF8001. lhu with a=0: 0x00001234.
- jal with PC8=0x00003008: `A3_W`=31, `result_W`=0x00003008. addu with rd=0: `RegWrite_W`=0, `result_W`=0.
- Stall and flush:
  - Load addu; hold `en_W`=0 for 3 cycles: outputs are stable.
  - Assert `flush_W` together with `en_W`: next cycle `instr_W`=0 and `RegWrite_W`=0.
- With `HAS_MD`=1, mfhi with MDout=0x12345678 and rd=8: writes 0x12345678. With `HAS_MD`=0, the same instruction gives `RegWrite_W`=0.
